// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants: PC type, PC generator states,
// boot address and the meaning of each redirect channel.
package cpu_fetch_pkg;

  typedef logic [31:0] pc_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pcgen_state_e;

  localparam pc_t RESET_PC_DEFAULT = 32'hbfc0_0000;

  // Redirect channels in priority order; a lower index wins.
  localparam int CH_TRAP       = 0;
  localparam int CH_MISPRED_NT = 1;
  localparam int CH_MISPRED_T  = 2;
  localparam int CH_JUMP_D     = 3;
  localparam int CH_PRED_D     = 4;

endpackage

// File: rtl/redir_arb.sv
// Fixed-priority arbiter: the lowest-index valid request wins and its data is
// forwarded. Purely combinational so it can be shared with the refill path.
module redir_arb #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic                    win_valid,
  output logic [IDX_W-1:0]        win_idx,
  output logic [DATA_W-1:0]       win_pc
);

  // Walk from lowest to highest priority so the lowest valid index is left standing.
  always_comb begin
    win_valid = |req_valid;
    win_idx   = {IDX_W{1'b0}};
    win_pc    = {DATA_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win_idx = req_valid[i] ? IDX_W'(i) : win_idx;
      win_pc  = req_valid[i] ? req_data[DATA_W*i +: DATA_W] : win_pc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, sequential fall-through,
// a pending-redirect buffer that survives stalls, and boot sequencing.
module pc_gen
  import cpu_fetch_pkg::*;
#(
  parameter int  FETCH_WIDTH = 2,
  parameter int  N_SRC       = 4,
  parameter pc_t RESET_PC    = RESET_PC_DEFAULT,
  localparam int SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_f,
  input  logic [N_SRC-1:0]       redir_valid,
  input  logic [N_SRC*32-1:0]    redir_pc,
  output logic [31:0]            pc_f,
  output logic                   fetch_valid_f,
  output logic [FETCH_WIDTH-1:0] slot_mask_f,
  output logic                   adel_f,
  output logic                   redir_applied,
  output logic [SRC_W-1:0]       redir_src
);

  localparam pc_t GB       = 32'(FETCH_WIDTH * 4);
  localparam pc_t GRP_MASK = ~(GB - 32'd1);

  pcgen_state_e     state_q, state_d;
  pc_t              pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  pc_t              pend_pc_q, pend_pc_d;
  logic [SRC_W-1:0] pend_idx_q, pend_idx_d;
  logic             applied_q, applied_d;
  logic [SRC_W-1:0] src_q, src_d;

  logic             win_valid;
  logic [SRC_W-1:0] win_idx;
  pc_t              win_pc;
  pc_t              seq_pc;
  pc_t              slot_idx;
  logic             take_new;

  redir_arb #(
    .N_SRC (N_SRC),
    .DATA_W(32)
  ) u_arb (
    .req_valid(redir_valid),
    .req_data (redir_pc),
    .win_valid(win_valid),
    .win_idx  (win_idx),
    .win_pc   (win_pc)
  );

  assign seq_pc   = (pc_q & GRP_MASK) + GB;
  assign take_new = win_valid && (!pend_v_q || (win_idx <= pend_idx_q));

  // Next-state and next-PC selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    pend_idx_d = pend_idx_q;
    applied_d  = 1'b0;
    src_d      = src_q;
    case (state_q)
      BOOT: begin
        if (win_valid) begin
          pend_v_d   = 1'b1;
          pend_pc_d  = win_pc;
          pend_idx_d = win_idx;
          state_d    = PEND;
        end else begin
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!stall_f && win_valid) begin
          pc_d      = win_pc;
          applied_d = 1'b1;
          src_d     = win_idx;
        end else if (!stall_f) begin
          pc_d      = seq_pc;
        end else if (win_valid) begin
          pend_v_d   = 1'b1;
          pend_pc_d  = win_pc;
          pend_idx_d = win_idx;
          state_d    = PEND;
        end else begin
          state_d    = RUN;
        end
      end
      PEND: begin
        if (stall_f && take_new) begin
          pend_pc_d  = win_pc;
          pend_idx_d = win_idx;
        end else if (!stall_f) begin
          pc_d      = take_new ? win_pc : pend_pc_q;
          src_d     = take_new ? win_idx : pend_idx_q;
          applied_d = 1'b1;
          pend_v_d  = 1'b0;
          state_d   = RUN;
        end else begin
          state_d   = PEND;
        end
      end
      default: begin
        state_d  = BOOT;
        pend_v_d = 1'b0;
      end
    endcase
  end

  // State, PC and pending-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'h0000_0000;
      pend_idx_q <= {SRC_W{1'b0}};
      applied_q  <= 1'b0;
      src_q      <= {SRC_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      pend_idx_q <= pend_idx_d;
      applied_q  <= applied_d;
      src_q      <= src_d;
    end
  end

  assign pc_f          = pc_q;
  assign fetch_valid_f = (state_q != BOOT);
  assign adel_f        = fetch_valid_f && (pc_q[1:0] != 2'b00);
  assign redir_applied = applied_q;
  assign redir_src     = src_q;

  // Slots before the entry slot of the group are not valid instructions.
  always_comb begin
    slot_idx = (pc_q >> 2'd2) & 32'(FETCH_WIDTH - 1);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_mask_f[i] = fetch_valid_f && (32'(i) >= slot_idx);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with two-wide fetch and five
// redirect channels; expected values are hand-computed constants.
module tb_pc_gen;
  import cpu_fetch_pkg::*;

  localparam int FW  = 2;
  localparam int NS  = 5;
  localparam int SW  = 3;

  logic              clk;
  logic              rst_n;
  logic              stall_f;
  logic [NS-1:0]     redir_valid;
  logic [NS*32-1:0]  redir_pc;
  logic [31:0]       pc_f;
  logic              fetch_valid_f;
  logic [FW-1:0]     slot_mask_f;
  logic              adel_f;
  logic              redir_applied;
  logic [SW-1:0]     redir_src;

  int checks   = 0;
  int failures = 0;

  pc_gen #(
    .FETCH_WIDTH(FW),
    .N_SRC      (NS),
    .RESET_PC   (32'hbfc0_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_f      (stall_f),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .pc_f         (pc_f),
    .fetch_valid_f(fetch_valid_f),
    .slot_mask_f  (slot_mask_f),
    .adel_f       (adel_f),
    .redir_applied(redir_applied),
    .redir_src    (redir_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input int ch, input logic [31:0] tgt);
    redir_valid[ch]        = 1'b1;
    redir_pc[32*ch +: 32]  = tgt;
  endtask

  task automatic clr_redir();
    redir_valid = '0;
    redir_pc    = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    stall_f = 1'b0;
    clr_redir();
    #12;
    // 1. reset state, boot, sequential run
    chk("rst_pc", pc_f, 32'hbfc0_0000);
    chk("rst_valid", {31'd0, fetch_valid_f}, 32'd0);
    chk("rst_applied", {31'd0, redir_applied}, 32'd0);
    chk("rst_src", {29'd0, redir_src}, 32'd0);
    rst_n = 1'b1;
    stall_f = 1'b1;  // ignored in BOOT
    tick();
    stall_f = 1'b0;
    chk("boot_pc", pc_f, 32'hbfc0_0000);
    chk("boot_valid", {31'd0, fetch_valid_f}, 32'd1);
    chk("boot_mask", {30'd0, slot_mask_f}, 32'd3);
    tick();
    chk("seq1_pc", pc_f, 32'hbfc0_0008);
    tick();
    chk("seq2_pc", pc_f, 32'hbfc0_0010);
    chk("seq2_applied", {31'd0, redir_applied}, 32'd0);

    // 2. odd-slot entry via jump channel
    set_redir(CH_JUMP_D, 32'h8000_1004);
    tick();
    clr_redir();
    chk("odd_pc", pc_f, 32'h8000_1004);
    chk("odd_mask", {30'd0, slot_mask_f}, 32'd2);
    chk("odd_applied", {31'd0, redir_applied}, 32'd1);
    chk("odd_src", {29'd0, redir_src}, 32'd3);
    tick();
    chk("odd_next_pc", pc_f, 32'h8000_1008);
    chk("odd_next_applied", {31'd0, redir_applied}, 32'd0);
    chk("odd_next_src_hold", {29'd0, redir_src}, 32'd3);

    // 3. simultaneous redirects
    set_redir(CH_MISPRED_NT, 32'h8000_2000);
    set_redir(CH_PRED_D, 32'h8000_3000);
    tick();
    clr_redir();
    chk("simul_pc", pc_f, 32'h8000_2000);
    chk("simul_src", {29'd0, redir_src}, 32'd1);

    // 4. redirects raised during a stall
    stall_f = 1'b1;
    set_redir(CH_JUMP_D, 32'h8000_4000);
    tick();
    clr_redir();
    chk("stall1_pc", pc_f, 32'h8000_2000);
    chk("stall1_valid", {31'd0, fetch_valid_f}, 32'd1);
    chk("stall1_applied", {31'd0, redir_applied}, 32'd0);
    set_redir(CH_PRED_D, 32'h8000_5000);
    tick();
    clr_redir();
    chk("stall2_pc", pc_f, 32'h8000_2000);
    set_redir(CH_TRAP, 32'hbfc0_0380);
    tick();
    clr_redir();
    chk("stall3_pc", pc_f, 32'h8000_2000);
    chk("stall3_applied", {31'd0, redir_applied}, 32'd0);
    stall_f = 1'b0;
    tick();
    chk("release_pc", pc_f, 32'hbfc0_0380);
    chk("release_applied", {31'd0, redir_applied}, 32'd1);
    chk("release_src", {29'd0, redir_src}, 32'd0);
    tick();
    chk("after_release_pc", pc_f, 32'hbfc0_0388);
    chk("after_release_applied", {31'd0, redir_applied}, 32'd0);

    // 5. misalignment and wrap-around
    set_redir(CH_MISPRED_T, 32'h8000_0002);
    tick();
    clr_redir();
    chk("mis_pc", pc_f, 32'h8000_0002);
    chk("mis_adel", {31'd0, adel_f}, 32'd1);
    chk("mis_mask", {30'd0, slot_mask_f}, 32'd3);
    tick();
    chk("mis_next_pc", pc_f, 32'h8000_0008);
    chk("mis_next_adel", {31'd0, adel_f}, 32'd0);
    set_redir(CH_JUMP_D, 32'hffff_fff8);
    tick();
    clr_redir();
    chk("wrap_pre_pc", pc_f, 32'hffff_fff8);
    tick();
    chk("wrap_pc", pc_f, 32'h0000_0000);

    // 6. reset while a redirect is pending
    stall_f = 1'b1;
    set_redir(CH_MISPRED_T, 32'h8000_6000);
    tick();
    clr_redir();
    chk("pend_hold_pc", pc_f, 32'h0000_0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("pend_rst_pc", pc_f, 32'hbfc0_0000);
    chk("pend_rst_valid", {31'd0, fetch_valid_f}, 32'd0);
    chk("pend_rst_applied", {31'd0, redir_applied}, 32'd0);
    stall_f = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_boot_pc", pc_f, 32'hbfc0_0000);
    chk("post_rst_valid", {31'd0, fetch_valid_f}, 32'd1);
    tick();
    chk("post_rst_seq_pc", pc_f, 32'hbfc0_0008);
    chk("post_rst_applied", {31'd0, redir_applied}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
